// File: rtl/pipe_pkg.sv
// Shared constants for the CPU pipeline-stage registers.
// Control-bundle bit positions, default widths and occupancy encodings.
package pipe_pkg;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_ALUOP_W  = 2;

    localparam int CTRL_W_DEF = 8;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/pipe_reg_entry.sv
// One pipeline entry: valid bit, control and data payload; clear has priority over load.
// Clearing drops valid and zeroes control (bubble) while the data payload is kept.
module pipe_reg_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int PAY_W  = 96
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [PAY_W-1:0]  data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [PAY_W-1:0]  data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [PAY_W-1:0]  data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_ctrl_stage.sv
// Pipeline-stage register with valid/ready, flush-to-bubble and optional skid entry; 1-cycle latency.
// SKID=1: ready_o is registered (~skid valid); SKID=0: ready_o = ~valid_o | ready_i.
module pipe_ctrl_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = 32,
    parameter int DATA_N = 3,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [CTRL_W-1:0]        ctrl_i,
    input  logic [DATA_N*DATA_W-1:0] data_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [CTRL_W-1:0]        ctrl_o,
    output logic [DATA_N*DATA_W-1:0] data_o,
    output logic [1:0]               occ_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    localparam int PAY_W = DATA_N * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              main_vld, skid_vld;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [PAY_W-1:0]  main_data, skid_data;

    logic              in_fire, out_fire;
    logic              main_load, main_clr, main_from_skid;
    logic              skid_load, skid_clr;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [PAY_W-1:0]  main_data_in;

    logic [CNT_W-1:0]  stall_q, stall_d;

    assign in_fire  = valid_i & ready_o;
    assign out_fire = main_vld & ready_i;

    // Flush outranks every handshake transition; an occupied skid always drains into main first.
    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush_i) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (skid_vld) begin
            if (out_fire) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clr       = 1'b1;
            end
        end else if (main_vld) begin
            case ({in_fire, out_fire})
                2'b11:   main_load = 1'b1;
                2'b10:   skid_load = 1'b1;
                2'b01:   main_clr  = 1'b1;
                default: ;
            endcase
        end else if (in_fire) begin
            main_load = 1'b1;
        end
    end

    assign main_ctrl_in = main_from_skid ? skid_ctrl : ctrl_i;
    assign main_data_in = main_from_skid ? skid_data : data_i;

    pipe_reg_entry #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (main_load),
        .clr_i   (main_clr),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .valid_o (main_vld),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_reg_entry #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_skid (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .load_i  (skid_load),
                .clr_i   (skid_clr),
                .ctrl_i  (ctrl_i),
                .data_i  (data_i),
                .valid_o (skid_vld),
                .ctrl_o  (skid_ctrl),
                .data_o  (skid_data)
            );
            assign ready_o = ~skid_vld;
        end else begin : g_noskid
            assign skid_vld  = 1'b0;
            assign skid_ctrl = '0;
            assign skid_data = '0;
            assign ready_o   = ~main_vld | ready_i;
        end
    endgenerate

    always_comb begin
        stall_d = stall_q;
        if (main_vld && !ready_i && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    always_comb begin
        occ_o = OCC_EMPTY;
        if (skid_vld) begin
            occ_o = OCC_TWO;
        end else if (main_vld) begin
            occ_o = OCC_ONE;
        end
    end

    assign valid_o     = main_vld;
    assign ctrl_o      = main_ctrl;
    assign data_o      = main_data;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Bench for pipe_ctrl_stage: three instances (SKID=1, SKID=0, SKID=1 with CNT_W=4)
// checked every cycle against a queue-based model of the stage.
module tb_pipe_ctrl_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        vld, rdy, flush;
    logic [7:0]  ctrl;
    logic [95:0] data;
    int          sel;

    logic [2:0] vi, fl;
    always_comb begin
        vi = 3'b000;
        fl = 3'b000;
        vi[sel] = vld;
        fl[sel] = flush;
    end

    logic        ro0, vo0, ro1, vo1, ro2, vo2;
    logic [7:0]  co0, co1, co2;
    logic [95:0] do0, do1, do2;
    logic [1:0]  oc0, oc1, oc2;
    logic [15:0] st0, st1;
    logic [3:0]  st2;

    pipe_ctrl_stage #(.SKID(1)) u_sk1 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(fl[0]), .valid_i(vi[0]), .ready_o(ro0),
        .ctrl_i(ctrl), .data_i(data), .valid_o(vo0), .ready_i(rdy), .ctrl_o(co0),
        .data_o(do0), .occ_o(oc0), .stall_cnt_o(st0));

    pipe_ctrl_stage #(.SKID(0)) u_sk0 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(fl[1]), .valid_i(vi[1]), .ready_o(ro1),
        .ctrl_i(ctrl), .data_i(data), .valid_o(vo1), .ready_i(rdy), .ctrl_o(co1),
        .data_o(do1), .occ_o(oc1), .stall_cnt_o(st1));

    pipe_ctrl_stage #(.SKID(1), .CNT_W(4)) u_c4 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(fl[2]), .valid_i(vi[2]), .ready_o(ro2),
        .ctrl_i(ctrl), .data_i(data), .valid_o(vo2), .ready_i(rdy), .ctrl_o(co2),
        .data_o(do2), .occ_o(oc2), .stall_cnt_o(st2));

    // Observation vector of the selected instance: {valid, ctrl, data, occ, ready, stall}.
    logic [123:0] obs;
    always_comb begin
        case (sel)
            0:       obs = {vo0, co0, do0, oc0, ro0, st0};
            1:       obs = {vo1, co1, do1, oc1, ro1, st1};
            default: obs = {vo2, co2, do2, oc2, ro2, 12'h000, st2};
        endcase
    end

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0]  c;
        logic [95:0] d;
    } ent_t;

    ent_t        q[$];
    logic [95:0] m_last;
    int          m_stall;
    int          m_max;
    bit          m_skid;

    function automatic bit m_ready();
        if (m_skid) return (q.size() < 2);
        return (q.size() == 0) || rdy;
    endfunction

    function automatic logic [123:0] exp_obs();
        logic       v;
        logic [7:0] c;
        v = (q.size() > 0);
        c = v ? q[0].c : 8'h00;
        return {v, c, m_last, 2'(q.size()), m_ready(), 16'(m_stall)};
    endfunction

    task automatic cycle(input bit v, input logic [7:0] c, input logic [95:0] d,
                         input bit r, input bit f, output bit acc);
        bit   inf, outf, stl;
        ent_t e;
        vld = v; ctrl = c; data = d; rdy = r; flush = f;
        inf  = v && m_ready();
        outf = (q.size() > 0) && r;
        stl  = (q.size() > 0) && !r;
        @(posedge clk);
        if (stl && m_stall < m_max) m_stall++;
        if (f) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) begin
                e.c = c; e.d = d;
                q.push_back(e);
            end
        end
        if (q.size() > 0) m_last = q[0].d;
        acc = inf && !f;
        @(negedge clk);
    endtask

    task automatic do_reset(input int s);
        sel = s;
        m_skid = (s != 1);
        m_max  = (s == 2) ? 15 : 65535;
        vld = 1'b0; rdy = 1'b0; flush = 1'b0; ctrl = '0; data = '0;
        rst_n = 1'b0;
        q.delete();
        m_last = '0;
        m_stall = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        bit acc;
        sel = 0; m_skid = 1; m_max = 65535;
        vld = 1'b0; rdy = 1'b0; flush = 1'b0; ctrl = '0; data = '0;
        q.delete(); m_last = '0; m_stall = 0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL reset_async actual=%h required=%h", obs, exp_obs());
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL reset_held actual=%h required=%h", obs, exp_obs());
        end
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
        checks++;
        if (ro0 !== 1'b1 || oc0 !== 2'd0 || vo0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release actual ready=%b occ=%0d valid=%b required ready=1 occ=0 valid=0",
                     ro0, oc0, vo0);
        end
    endtask

    task automatic test_single();
        bit          acc;
        logic [95:0] d;
        do_reset(0);
        d = {$urandom, $urandom, 32'h0000_1234};
        cycle(1'b1, 8'h3D, d, 1'b1, 1'b0, acc);
        checks++;
        if (vo0 !== 1'b1 || co0 !== 8'h3D || do0[31:0] !== 32'h1234 || obs !== exp_obs()) begin
            errors++;
            $display("FAIL single_out actual=%h required=%h", obs, exp_obs());
        end
        cycle(1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
        checks++;
        if (vo0 !== 1'b0 || co0 !== 8'h00 || obs !== exp_obs()) begin
            errors++;
            $display("FAIL single_bubble actual=%h required=%h", obs, exp_obs());
        end
    endtask

    task automatic test_backpressure();
        bit          acc, c_acc;
        logic [7:0]  ec[3];
        logic [95:0] ed[3];
        logic [7:0]  got_c[5];
        bit          got_v[5];
        for (int i = 0; i < 3; i++) begin
            ec[i] = 8'(8'h10 * (i + 1) + 1);
            ed[i] = rnd96();
        end
        do_reset(0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, ec[i], ed[i], 1'b0, 1'b0, acc);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL bp_fill%0d actual=%h required=%h", i, obs, exp_obs());
            end
        end
        checks++;
        if (acc !== 1'b0 || ro0 !== 1'b0 || oc0 !== 2'd2) begin
            errors++;
            $display("FAIL bp_c_held actual acc=%b ready=%b occ=%0d required acc=0 ready=0 occ=2",
                     acc, ro0, oc0);
        end
        c_acc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            got_v[i] = vo0;
            got_c[i] = co0;
            cycle(!c_acc, ec[2], ed[2], 1'b1, 1'b0, acc);
            if (acc) c_acc = 1'b1;
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL bp_drain%0d actual=%h required=%h", i, obs, exp_obs());
            end
        end
        checks++;
        if (!(got_v[0] && got_v[1] && got_v[2] && !got_v[3] && !got_v[4]) ||
            got_c[0] !== ec[0] || got_c[1] !== ec[1] || got_c[2] !== ec[2]) begin
            errors++;
            $display("FAIL bp_order actual=%b%b%b%b%b %h %h %h required=11100 %h %h %h",
                     got_v[0], got_v[1], got_v[2], got_v[3], got_v[4],
                     got_c[0], got_c[1], got_c[2], ec[0], ec[1], ec[2]);
        end
        checks++;
        if (st0 !== 16'd2) begin
            errors++;
            $display("FAIL bp_stall_cnt actual=%0d required=2", st0);
        end
    endtask

    task automatic test_flush_occ2();
        bit acc;
        do_reset(0);
        cycle(1'b1, 8'hA1, rnd96(), 1'b0, 1'b0, acc);
        cycle(1'b1, 8'hB2, rnd96(), 1'b0, 1'b0, acc);
        checks++;
        if (obs !== exp_obs()) begin
            errors++;
            $display("FAIL flush_pre actual=%h required=%h", obs, exp_obs());
        end
        cycle(1'b1, 8'hC3, rnd96(), 1'b0, 1'b1, acc);
        checks++;
        if (vo0 !== 1'b0 || co0 !== 8'h00 || oc0 !== 2'd0 || ro0 !== 1'b1 || obs !== exp_obs()) begin
            errors++;
            $display("FAIL flush_occ2 actual=%h required=%h", obs, exp_obs());
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
            checks++;
            if (vo0 !== 1'b0 || obs !== exp_obs()) begin
                errors++;
                $display("FAIL flush_after%0d actual=%h required=%h", i, obs, exp_obs());
            end
        end
    endtask

    task automatic test_stream_s0();
        bit acc;
        do_reset(1);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 8'(i), 96'(i), 1'b1, 1'b0, acc);
            checks++;
            if (vo1 !== 1'b1 || do1[31:0] !== 32'(i) || obs !== exp_obs()) begin
                errors++;
                $display("FAIL s0_stream%0d actual=%h required=%h", i, obs, exp_obs());
            end
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 8'd9, 96'd9, 1'b0, 1'b0, acc);
            checks++;
            if (ro1 !== 1'b0 || do1[31:0] !== 32'd8 || co1 !== 8'd8 || obs !== exp_obs()) begin
                errors++;
                $display("FAIL s0_hold%0d actual=%h required=%h", i, obs, exp_obs());
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL s0_drain%0d actual=%h required=%h", i, obs, exp_obs());
            end
        end
    endtask

    task automatic test_saturation();
        bit acc;
        do_reset(2);
        cycle(1'b1, 8'h55, rnd96(), 1'b0, 1'b0, acc);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 8'h00, '0, 1'b0, 1'b0, acc);
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL sat_cyc%0d actual=%h required=%h", i, obs, exp_obs());
            end
        end
        checks++;
        if (st2 !== 4'd15) begin
            errors++;
            $display("FAIL sat_final actual=%0d required=15", st2);
        end
    endtask

    task automatic test_async_reset();
        bit acc;
        do_reset(0);
        cycle(1'b1, 8'h11, rnd96(), 1'b0, 1'b0, acc);
        cycle(1'b1, 8'h22, rnd96(), 1'b0, 1'b0, acc);
        checks++;
        if (oc0 !== 2'd2) begin
            errors++;
            $display("FAIL areset_pre actual occ=%0d required occ=2", oc0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vo0 !== 1'b0 || co0 !== 8'h00 || do0 !== 96'h0 || oc0 !== 2'd0 || st0 !== 16'd0) begin
            errors++;
            $display("FAIL areset_now actual v=%b c=%h d=%h occ=%0d st=%0d required all zero",
                     vo0, co0, do0, oc0, st0);
        end
        q.delete(); m_last = '0; m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, '0, 1'b0, 1'b0, acc);
        checks++;
        if (ro0 !== 1'b1 || oc0 !== 2'd0 || obs !== exp_obs()) begin
            errors++;
            $display("FAIL areset_release actual=%h required=%h", obs, exp_obs());
        end
    endtask

    task automatic test_random(input int s);
        bit          acc, pend;
        logic [7:0]  pc;
        logic [95:0] pd;
        bit          r, f;
        do_reset(s);
        pend = 1'b0;
        pc = '0;
        pd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom_range(3) != 0)) begin
                pend = 1'b1;
                pc = 8'($urandom);
                pd = rnd96();
            end
            r = ($urandom_range(2) != 0);
            f = ($urandom_range(24) == 0);
            cycle(pend, pc, pd, r, f, acc);
            if (acc || f) pend = 1'b0;
            checks++;
            if (obs !== exp_obs()) begin
                errors++;
                $display("FAIL rand_s%0d_cyc%0d actual=%h required=%h", s, i, obs, exp_obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flush_occ2();
        test_stream_s0();
        test_saturation();
        test_async_reset();
        test_random(0);
        test_random(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
